// File: rtl/instruction_fetch_unit.sv
// Fetch sequencer: drives single-word reads to instruction memory and registers the word + PC for decode.
// Optional build macro IFU_PERF_CNT_EN adds perf_fetch_count / perf_wait_cycles outputs.
module instruction_fetch_unit #(
    parameter int          ADDR_W   = 5,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [31:0]       branch_target,
    output logic              imem_read,
    output logic [ADDR_W-1:0] imem_address,
    input  logic [31:0]       imem_instruction,
    input  logic              imem_busywait,
    output logic              if_valid,
    output logic [31:0]       if_instruction,
    output logic [31:0]       if_pc,
    output logic [31:0]       if_pc_plus4
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetch_count,
    output logic [31:0]       perf_wait_cycles
`endif
);

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_instruction_q, if_instruction_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_pc_plus4_q, if_pc_plus4_d;
    logic [31:0] redirect_pc_s;
    logic        capture_s;

    assign redirect_pc_s = branch_target & 32'hFFFF_FFFC;

    // Memory-side strobes are combinational so a request goes out in the same cycle as FETCH
    assign imem_read    = (state_q == S_FETCH) & ~branch_taken & ~imem_busywait;
    assign imem_address = pc_q[ADDR_W+1:2];

    assign if_valid       = if_valid_q;
    assign if_instruction = if_instruction_q;
    assign if_pc          = if_pc_q;
    assign if_pc_plus4    = if_pc_plus4_q;

    // Next-state and datapath control; a redirect always wins over stall and memory status
    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        if_valid_d       = if_valid_q;
        if_instruction_d = if_instruction_q;
        if_pc_d          = if_pc_q;
        if_pc_plus4_d    = if_pc_plus4_q;
        capture_s        = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (branch_taken) begin
                    pc_d = redirect_pc_s;
                end else if (imem_busywait) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (branch_taken) begin
                    // The response of the abandoned request must never reach decode
                    pc_d    = redirect_pc_s;
                    state_d = imem_busywait ? S_FLUSH : S_FETCH;
                end else if (!imem_busywait) begin
                    capture_s        = 1'b1;
                    if_instruction_d = imem_instruction;
                    if_pc_d          = pc_q;
                    if_pc_plus4_d    = pc_q + 32'd4;
                    if_valid_d       = 1'b1;
                    state_d          = S_HOLD;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_HOLD: begin
                if (branch_taken) begin
                    if_valid_d = 1'b0;
                    pc_d       = redirect_pc_s;
                    state_d    = S_FETCH;
                end else if (!stall) begin
                    if_valid_d = 1'b0;
                    pc_d       = pc_q + 32'd4;
                    state_d    = S_FETCH;
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_FLUSH: begin
                if (branch_taken) begin
                    pc_d = redirect_pc_s;
                end else begin
                    pc_d = pc_q;
                end
                if (!imem_busywait) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_FLUSH;
                end
            end
            default: begin
                state_d    = S_FETCH;
                if_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= S_FETCH;
            pc_q             <= RESET_PC & 32'hFFFF_FFFC;
            if_valid_q       <= 1'b0;
            if_instruction_q <= NOP_INSN;
            if_pc_q          <= RESET_PC;
            if_pc_plus4_q    <= RESET_PC + 32'd4;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            if_valid_q       <= if_valid_d;
            if_instruction_q <= if_instruction_d;
            if_pc_q          <= if_pc_d;
            if_pc_plus4_q    <= if_pc_plus4_d;
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_count_q;
    logic [31:0] perf_wait_cycles_q;

    // Performance counters, free-running and wrapping at 2^32
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_fetch_count_q <= 32'd0;
            perf_wait_cycles_q <= 32'd0;
        end else begin
            if (capture_s) begin
                perf_fetch_count_q <= perf_fetch_count_q + 32'd1;
            end else begin
                perf_fetch_count_q <= perf_fetch_count_q;
            end
            if ((state_q == S_WAIT) || (state_q == S_FLUSH)) begin
                perf_wait_cycles_q <= perf_wait_cycles_q + 32'd1;
            end else begin
                perf_wait_cycles_q <= perf_wait_cycles_q;
            end
        end
    end

    assign perf_fetch_count = perf_fetch_count_q;
    assign perf_wait_cycles = perf_wait_cycles_q;
`else
    logic unused_capture_s;
    assign unused_capture_s = capture_s;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit; memory word k reads as 32'hC0DE_0000 + k.
module tb_instruction_fetch_unit;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_read;
    logic [4:0]  imem_address;
    logic [31:0] imem_instruction;
    logic        imem_busywait;
    logic        if_valid;
    logic [31:0] if_instruction;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_count;
    logic [31:0] perf_wait_cycles;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    instruction_fetch_unit #(.ADDR_W(5), .RESET_PC(32'h0000_0000)) dut (
        .clock            (clock),
        .reset            (reset),
        .stall            (stall),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .imem_read        (imem_read),
        .imem_address     (imem_address),
        .imem_instruction (imem_instruction),
        .imem_busywait    (imem_busywait),
        .if_valid         (if_valid),
        .if_instruction   (if_instruction),
        .if_pc            (if_pc),
        .if_pc_plus4      (if_pc_plus4)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetch_count (perf_fetch_count),
        .perf_wait_cycles (perf_wait_cycles)
`endif
    );

    // Zero-wait memory model: data follows the address combinationally
    assign imem_instruction = 32'hC0DE_0000 + {27'd0, imem_address};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // One complete fetch from FETCH at byte address pc with no stall or wait states
    task automatic fetch_one(input logic [31:0] pc);
        logic [31:0] word;
        word = 32'hC0DE_0000 + {27'd0, pc[6:2]};
        chk("fetch_read", {31'd0, imem_read}, 32'd1);
        chk("fetch_addr", {27'd0, imem_address}, {27'd0, pc[6:2]});
        step();
        chk("wait_valid", {31'd0, if_valid}, 32'd0);
        chk("wait_read", {31'd0, imem_read}, 32'd0);
        step();
        chk("hold_valid", {31'd0, if_valid}, 32'd1);
        chk("hold_pc", if_pc, pc);
        chk("hold_insn", if_instruction, word);
        chk("hold_pc4", if_pc_plus4, pc + 32'd4);
        chk("hold_read", {31'd0, imem_read}, 32'd0);
        step();
        chk("next_valid", {31'd0, if_valid}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0;
        branch_target = 32'd0; imem_busywait = 1'b0;

        // Reset values
        do_reset();
        #1;
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_insn", if_instruction, 32'h0000_0013);
        chk("rst_pc", if_pc, 32'd0);
        chk("rst_pc4", if_pc_plus4, 32'd4);
        chk("rst_addr", {27'd0, imem_address}, 32'd0);

        // Straight-line fetch of words 0..7
        for (int k = 0; k < 8; k++) fetch_one(32'(k * 4));

        // Stall for 5 cycles while holding pc=8
        do_reset();
        fetch_one(32'h0);
        fetch_one(32'h4);
        step();
        step();
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_valid", {31'd0, if_valid}, 32'd1);
            chk("stall_pc", if_pc, 32'h8);
            chk("stall_insn", if_instruction, 32'hC0DE_0002);
            chk("stall_read", {31'd0, imem_read}, 32'd0);
        end
        stall = 1'b0;
        step();
        chk("unstall_valid", {31'd0, if_valid}, 32'd0);
        fetch_one(32'hC);

        // Memory busy for 3 cycles after the request at pc=4
        do_reset();
        fetch_one(32'h0);
        step();
        imem_busywait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("busy_valid", {31'd0, if_valid}, 32'd0);
            chk("busy_read", {31'd0, imem_read}, 32'd0);
        end
        imem_busywait = 1'b0;
        step();
        chk("busy_cap_valid", {31'd0, if_valid}, 32'd1);
        chk("busy_cap_pc", if_pc, 32'h4);
        chk("busy_cap_insn", if_instruction, 32'hC0DE_0001);
        step();

        // Redirect to 0x14 while WAIT with memory busy -> FLUSH, old word dropped
        step();
        imem_busywait = 1'b1;
        step();
        branch_taken = 1'b1; branch_target = 32'h14;
        #1;
        chk("br_wait_read", {31'd0, imem_read}, 32'd0);
        step();
        branch_taken = 1'b0;
        chk("flush_valid0", {31'd0, if_valid}, 32'd0);
        step();
        chk("flush_valid1", {31'd0, if_valid}, 32'd0);
        imem_busywait = 1'b0;
        step();
        chk("flush_exit_valid", {31'd0, if_valid}, 32'd0);
        fetch_one(32'h14);

        // Redirect beats stall in HOLD; target 0x1E aligns to 0x1C
        step();
        step();
        chk("hold18_pc", if_pc, 32'h18);
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h1E;
        step();
        stall = 1'b0; branch_taken = 1'b0;
        #1;
        chk("br_hold_valid", {31'd0, if_valid}, 32'd0);
        chk("br_hold_addr", {27'd0, imem_address}, 32'd7);
        fetch_one(32'h1C);

        // Redirect from FETCH to the top of the address space; pc+4 wraps to 0
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
        #1;
        chk("br_fetch_read", {31'd0, imem_read}, 32'd0);
        step();
        branch_taken = 1'b0;
        #1;
        fetch_one(32'hFFFF_FFFC);
        chk("wrap_addr", {27'd0, imem_address}, 32'd0);

        // Reset in the middle of WAIT at pc=12; stale response must be ignored
        do_reset();
        fetch_one(32'h0);
        fetch_one(32'h4);
        fetch_one(32'h8);
        step();
        imem_busywait = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_valid", {31'd0, if_valid}, 32'd0);
        chk("mid_rst_pc", if_pc, 32'h0);
        chk("mid_rst_addr", {27'd0, imem_address}, 32'd0);
        chk("mid_rst_read_busy", {31'd0, imem_read}, 32'd0);
        step();
        chk("mid_rst_stale_valid", {31'd0, if_valid}, 32'd0);
        imem_busywait = 1'b0;
        #1;
        fetch_one(32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
